// File: rtl/rx_packet_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rx_packet_ctrl_pkg
// Constants shared by the packet receiver and the transmitter side: command
// codes, packet-FSM state encodings, checksum width and the checksum step.
// -----------------------------------------------------------------------------
package rx_packet_ctrl_pkg;

  // Checksum is a single XOR byte over cmd and payload
  localparam int CSUM_W = 8;

  // Command codes (first byte of every packet)
  localparam logic [7:0] CMD_CONN  = 8'h00;
  localparam logic [7:0] CMD_SCORE = 8'h01;
  localparam logic [7:0] CMD_MAP   = 8'h02;

  // Packet FSM state encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  // One accumulation step of the running packet checksum
  function automatic logic [CSUM_W-1:0] csum_step(input logic [CSUM_W-1:0] acc,
                                                  input logic [7:0]        data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/rx_packet_ctrl_uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, sampling each bit at its midpoint.
// Ports:
//   clk     - clock
//   i_rst   - asynchronous active-high reset
//   i_rx    - serial input, idle high
//   o_data  - received byte, valid while o_recv is high
//   o_recv  - one-cycle strobe per byte with a valid (high) stop bit
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_recv
);

  localparam int CNT_W = $clog2(CLK_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLK_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_PER_BIT - 1);

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  logic [1:0]       r_sync;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             w_rx;

  assign w_rx = r_sync[1];

  // Input synchroniser, bit-timing counter and byte assembly
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_state <= U_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      o_data  <= 8'h00;
      o_recv  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      o_recv <= 1'b0;
      case (r_state)
        U_IDLE: begin
          r_cnt <= {CNT_W{1'b0}};
          if (!w_rx) r_state <= U_START;
        end
        // Re-check the start bit at its midpoint to reject glitches
        U_START: begin
          if (r_cnt == HALF_BIT) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_bit   <= 3'd0;
            r_state <= w_rx ? U_IDLE : U_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        U_DATA: begin
          if (r_cnt == FULL_BIT) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= U_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // A low stop bit is a framing error: the byte is dropped
        U_STOP: begin
          if (r_cnt == FULL_BIT) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= U_IDLE;
            if (w_rx) begin
              o_recv <= 1'b1;
              o_data <= r_shift;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= U_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rx_packet_ctrl.sv
// -----------------------------------------------------------------------------
// rx_packet_ctrl
// Parses UART packets (cmd, payload, XOR checksum) and commits score/map
// payloads to the outputs only when the checksum matches.
// Ports:
//   clk          - clock
//   i_rst        - asynchronous active-high reset
//   i_rx         - UART serial input, idle high
//   i_clr        - synchronous clear of committed score and map
//   o_ctrl_conn  - one-cycle pulse on a connect command
//   o_score_upd  - one-cycle pulse when o_score is committed
//   o_map_upd    - one-cycle pulse when o_map is committed
//   o_err        - one-cycle pulse on bad cmd, bad checksum or timeout
//   o_busy       - high while a packet is in progress
//   o_score      - committed score (first payload byte in the MSBs)
//   o_map        - committed map (first payload byte in the MSBs)
// -----------------------------------------------------------------------------
module rx_packet_ctrl
  import rx_packet_ctrl_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int SCORE_BYTES = 2,
  parameter int MAP_BYTES   = 16,
  parameter int TIMEOUT_CYC = 20 * CLK_PER_BIT * 10
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_rx,
  input  logic                   i_clr,
  output logic                   o_ctrl_conn,
  output logic                   o_score_upd,
  output logic                   o_map_upd,
  output logic                   o_err,
  output logic                   o_busy,
  output logic [8*SCORE_BYTES-1:0] o_score,
  output logic [8*MAP_BYTES-1:0]   o_map
);

  localparam int MAX_BYTES = (SCORE_BYTES > MAP_BYTES) ? SCORE_BYTES : MAP_BYTES;
  localparam int SH_W      = 8 * MAX_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);
  localparam int LSB_W     = $clog2(SH_W);
  localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);

  logic [7:0]        w_data;
  logic              w_recv;
  logic [1:0]        r_state;
  logic              r_is_map;
  logic [CNT_W-1:0]  r_cnt;
  logic [CSUM_W-1:0] r_xor;
  logic [SH_W-1:0]   r_shadow;
  logic [TMO_W-1:0]  r_tmo;
  logic              w_tmo;
  logic              w_byte;
  logic [CNT_W-1:0]  w_last;
  logic [LSB_W-1:0]  w_lsb;

  uart_rx #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_uart_rx (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_rx   (i_rx),
    .o_data (w_data),
    .o_recv (w_recv)
  );

  // A byte landing on the timeout cycle belongs to no packet and is dropped
  assign w_tmo  = (r_state != ST_IDLE) && (r_tmo == TMO_W'(TIMEOUT_CYC));
  assign w_byte = w_recv && !w_tmo;

  // Payload byte k lands at bits [8*(N-k)-1 -: 8], so byte 0 ends in the MSBs
  assign w_last = r_is_map ? CNT_W'(MAP_BYTES - 1) : CNT_W'(SCORE_BYTES - 1);
  assign w_lsb  = LSB_W'({w_last - r_cnt, 3'b000});

  assign o_busy = (r_state != ST_IDLE);

  // Packet FSM, shadow buffer, inter-byte timeout and committed outputs
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_is_map    <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_xor       <= {CSUM_W{1'b0}};
      r_shadow    <= {SH_W{1'b0}};
      r_tmo       <= {TMO_W{1'b0}};
      o_ctrl_conn <= 1'b0;
      o_score_upd <= 1'b0;
      o_map_upd   <= 1'b0;
      o_err       <= 1'b0;
      o_score     <= {(8*SCORE_BYTES){1'b0}};
      o_map       <= {(8*MAP_BYTES){1'b0}};
    end else begin
      o_ctrl_conn <= 1'b0;
      o_score_upd <= 1'b0;
      o_map_upd   <= 1'b0;
      o_err       <= 1'b0;
      // Clear first; a commit later in this block overrides it for its target
      if (i_clr) begin
        o_score <= {(8*SCORE_BYTES){1'b0}};
        o_map   <= {(8*MAP_BYTES){1'b0}};
      end
      if (w_tmo) begin
        o_err   <= 1'b1;
        r_state <= ST_IDLE;
        r_tmo   <= {TMO_W{1'b0}};
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_tmo <= {TMO_W{1'b0}};
            if (w_byte) begin
              case (w_data)
                CMD_CONN: o_ctrl_conn <= 1'b1;
                CMD_SCORE, CMD_MAP: begin
                  r_is_map <= (w_data == CMD_MAP);
                  r_cnt    <= {CNT_W{1'b0}};
                  r_xor    <= w_data;
                  r_state  <= ST_PAYLOAD;
                end
                default: o_err <= 1'b1;
              endcase
            end
          end
          ST_PAYLOAD: begin
            if (w_byte) begin
              r_shadow[w_lsb +: 8] <= w_data;
              r_xor <= csum_step(r_xor, w_data);
              r_cnt <= r_cnt + CNT_W'(1);
              r_tmo <= {TMO_W{1'b0}};
              if (r_cnt == w_last) r_state <= ST_CHECK;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
          end
          ST_CHECK: begin
            if (w_byte) begin
              if (w_data == r_xor) begin
                if (r_is_map) begin
                  o_map     <= r_shadow[8*MAP_BYTES-1:0];
                  o_map_upd <= 1'b1;
                end else begin
                  o_score     <= r_shadow[8*SCORE_BYTES-1:0];
                  o_score_upd <= 1'b1;
                end
              end else begin
                o_err <= 1'b1;
              end
              r_state <= ST_IDLE;
              r_tmo   <= {TMO_W{1'b0}};
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_packet_ctrl
// Directed scenarios plus randomized packets checked against a packet-level
// reference model (checksum and payload value computed from the byte list).
// -----------------------------------------------------------------------------
module tb_rx_packet_ctrl;

  localparam int CPB = 8;
  localparam int SB  = 2;
  localparam int MB  = 16;
  localparam int TMO = 20 * CPB * 10;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_rx = 1'b1;
  logic            i_clr = 1'b0;
  logic            o_ctrl_conn, o_score_upd, o_map_upd, o_err, o_busy;
  logic [8*SB-1:0] o_score;
  logic [8*MB-1:0] o_map;

  always #5 clk = ~clk;

  rx_packet_ctrl #(
    .CLK_PER_BIT(CPB),
    .SCORE_BYTES(SB),
    .MAP_BYTES  (MB),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_rx       (i_rx),
    .i_clr      (i_clr),
    .o_ctrl_conn(o_ctrl_conn),
    .o_score_upd(o_score_upd),
    .o_map_upd  (o_map_upd),
    .o_err      (o_err),
    .o_busy     (o_busy),
    .o_score    (o_score),
    .o_map      (o_map)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_conn = 0, n_err = 0, n_supd = 0, n_mupd = 0;
  int b_conn, b_err, b_supd, b_mupd;
  logic [8*SB-1:0] exp_score;
  logic [8*MB-1:0] exp_map;
  logic [7:0]      q[$];

  // Count high cycles of every pulse output (a stuck pulse counts more than once)
  always @(negedge clk) begin
    if (o_ctrl_conn) n_conn++;
    if (o_err)       n_err++;
    if (o_score_upd) n_supd++;
    if (o_map_upd)   n_mupd++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_conn = n_conn; b_err = n_err; b_supd = n_supd; b_mupd = n_mupd;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      idle(CPB);
    end
    i_rx = 1'b1;
    idle(CPB);
  endtask

  // Send n bytes of v, most significant byte first
  task automatic send_bytes(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_byte(v[8*i +: 8]);
    idle(2 * CPB);
  endtask

  task automatic send_q();
    foreach (q[i]) send_byte(q[i]);
    idle(2 * CPB);
  endtask

  // kind: 0 conn, 1 score ok, 2 score bad csum, 3 map ok, 4 map bad csum, 5 bad cmd
  task automatic build(input int kind);
    logic [7:0] cs;
    int n;
    q.delete();
    if (kind == 0) begin
      q.push_back(8'h00);
    end else if (kind == 5) begin
      q.push_back(8'($urandom_range(3, 255)));
    end else begin
      q.push_back((kind <= 2) ? 8'h01 : 8'h02);
      n  = (kind <= 2) ? SB : MB;
      cs = q[0];
      for (int k = 0; k < n; k++) begin
        q.push_back(8'($urandom_range(0, 255)));
        cs = cs ^ q[k+1];
      end
      if (kind == 2 || kind == 4) cs = cs ^ 8'($urandom_range(1, 255));
      q.push_back(cs);
    end
  endtask

  // Reference model: outcome of one complete packet held in q
  task automatic model(output int ec, output int ee, output int es, output int em);
    logic [7:0]      x;
    logic [8*MB-1:0] val;
    int n;
    ec = 0; ee = 0; es = 0; em = 0;
    if (q[0] == 8'h00) begin
      ec = 1;
    end else if (q[0] == 8'h01 || q[0] == 8'h02) begin
      n   = (q[0] == 8'h01) ? SB : MB;
      x   = q[0];
      val = '0;
      for (int k = 1; k <= n; k++) begin
        x   = x ^ q[k];
        val = (val << 8) | (8*MB)'(q[k]);
      end
      if (q[n+1] == x) begin
        if (q[0] == 8'h01) begin exp_score = val[8*SB-1:0]; es = 1; end
        else begin exp_map = val; em = 1; end
      end else begin
        ee = 1;
      end
    end else begin
      ee = 1;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_rx = 1'b1; i_clr = 1'b0;
    idle(4);
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset.busy got=%b want=0", o_busy); end
    n_tests++; if (o_score !== '0) begin n_fail++; $display("FAIL reset.score got=%h want=0", o_score); end
    n_tests++; if (o_map !== '0) begin n_fail++; $display("FAIL reset.map got=%h want=0", o_map); end
    i_rst = 1'b0;
    idle(4);
    n_tests++; if (n_conn + n_err + n_supd + n_mupd !== 0) begin n_fail++; $display("FAIL reset.pulses got=%0d want=0", n_conn + n_err + n_supd + n_mupd); end
    exp_score = '0; exp_map = '0;
  endtask

  task automatic test_connect();
    snap();
    send_bytes(64'h00, 1);
    n_tests++; if (n_conn - b_conn !== 1) begin n_fail++; $display("FAIL connect.conn got=%0d want=1", n_conn - b_conn); end
    n_tests++; if (n_err - b_err !== 0) begin n_fail++; $display("FAIL connect.err got=%0d want=0", n_err - b_err); end
    n_tests++; if ((n_supd - b_supd) + (n_mupd - b_mupd) !== 0) begin n_fail++; $display("FAIL connect.upd got=%0d want=0", (n_supd - b_supd) + (n_mupd - b_mupd)); end
    n_tests++; if (o_score !== exp_score || o_map !== exp_map) begin n_fail++; $display("FAIL connect.outputs score=%h map=%h want unchanged", o_score, o_map); end
  endtask

  task automatic test_score_valid();
    snap();
    send_bytes(64'h01123427, 4);
    exp_score = 16'h1234;
    n_tests++; if (o_score !== 16'h1234) begin n_fail++; $display("FAIL score_valid.score got=%h want=1234", o_score); end
    n_tests++; if (n_supd - b_supd !== 1) begin n_fail++; $display("FAIL score_valid.upd got=%0d want=1", n_supd - b_supd); end
    n_tests++; if (n_err - b_err !== 0) begin n_fail++; $display("FAIL score_valid.err got=%0d want=0", n_err - b_err); end
  endtask

  task automatic test_score_bad();
    snap();
    send_bytes(64'h01123400, 4);
    n_tests++; if (n_err - b_err !== 1) begin n_fail++; $display("FAIL score_bad.err got=%0d want=1", n_err - b_err); end
    n_tests++; if (n_supd - b_supd !== 0) begin n_fail++; $display("FAIL score_bad.upd got=%0d want=0", n_supd - b_supd); end
    n_tests++; if (o_score !== 16'h1234) begin n_fail++; $display("FAIL score_bad.score got=%h want=1234", o_score); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL score_bad.busy got=%b want=0", o_busy); end
  endtask

  task automatic test_bad_cmd();
    snap();
    send_bytes(64'h7F, 1);
    n_tests++; if (n_err - b_err !== 1) begin n_fail++; $display("FAIL bad_cmd.err got=%0d want=1", n_err - b_err); end
    n_tests++; if (n_conn - b_conn !== 0) begin n_fail++; $display("FAIL bad_cmd.conn got=%0d want=0", n_conn - b_conn); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bad_cmd.busy got=%b want=0", o_busy); end
  endtask

  task automatic test_timeout();
    int ec, ee, es, em;
    snap();
    send_byte(8'h02);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(0, 255)));
    n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL timeout.busy_mid got=%b want=1", o_busy); end
    idle(TMO + 50);
    n_tests++; if (n_err - b_err !== 1) begin n_fail++; $display("FAIL timeout.err got=%0d want=1", n_err - b_err); end
    n_tests++; if (o_map !== exp_map) begin n_fail++; $display("FAIL timeout.map got=%h want=%h", o_map, exp_map); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL timeout.busy_after got=%b want=0", o_busy); end
    build(3);
    model(ec, ee, es, em);
    snap();
    send_q();
    n_tests++; if (o_map !== exp_map) begin n_fail++; $display("FAIL timeout.next_map got=%h want=%h", o_map, exp_map); end
    n_tests++; if (n_mupd - b_mupd !== em) begin n_fail++; $display("FAIL timeout.next_upd got=%0d want=%0d", n_mupd - b_mupd, em); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h02);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(0, 255)));
    snap();
    i_rst = 1'b1;
    idle(3);
    i_rst = 1'b0;
    idle(2);
    exp_score = '0; exp_map = '0;
    n_tests++; if (o_score !== '0 || o_map !== '0) begin n_fail++; $display("FAIL reset_mid.outputs score=%h map=%h want 0", o_score, o_map); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid.busy got=%b want=0", o_busy); end
    n_tests++; if (n_err - b_err !== 0) begin n_fail++; $display("FAIL reset_mid.err got=%0d want=0", n_err - b_err); end
    snap();
    send_bytes(64'h01ABCD67, 4);
    exp_score = 16'hABCD;
    n_tests++; if (o_score !== 16'hABCD) begin n_fail++; $display("FAIL reset_mid.next_score got=%h want=abcd", o_score); end
    n_tests++; if (n_supd - b_supd !== 1) begin n_fail++; $display("FAIL reset_mid.next_upd got=%0d want=1", n_supd - b_supd); end
  endtask

  task automatic test_clr_commit();
    int ec, ee, es, em;
    logic seen;
    build(3);
    q[1] = q[1] | 8'h01;
    q[MB+1] = q[MB+1] ^ 8'h01;
    model(ec, ee, es, em);
    send_q();
    n_tests++; if (o_map !== exp_map) begin n_fail++; $display("FAIL clr_commit.map_pre got=%h want=%h", o_map, exp_map); end
    snap();
    send_byte(8'h01); send_byte(8'h56); send_byte(8'h78);
    i_clr = 1'b1;
    seen  = 1'b0;
    fork
      send_byte(8'h2F);
      begin
        for (int k = 0; k < 20 * CPB && !o_score_upd; k++) @(negedge clk);
        seen  = o_score_upd;
        i_clr = 1'b0;
      end
    join
    idle(2 * CPB);
    exp_score = 16'h5678; exp_map = '0;
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL clr_commit.upd_seen got=%b want=1", seen); end
    n_tests++; if (o_score !== 16'h5678) begin n_fail++; $display("FAIL clr_commit.score got=%h want=5678", o_score); end
    n_tests++; if (o_map !== '0) begin n_fail++; $display("FAIL clr_commit.map got=%h want=0", o_map); end
    n_tests++; if (n_supd - b_supd !== 1) begin n_fail++; $display("FAIL clr_commit.upd got=%0d want=1", n_supd - b_supd); end
  endtask

  task automatic test_random();
    int ec, ee, es, em;
    for (int p = 0; p < 12; p++) begin
      build(int'($urandom_range(0, 5)));
      model(ec, ee, es, em);
      snap();
      send_q();
      n_tests++; if (n_conn - b_conn !== ec) begin n_fail++; $display("FAIL random%0d.conn got=%0d want=%0d", p, n_conn - b_conn, ec); end
      n_tests++; if (n_err - b_err !== ee) begin n_fail++; $display("FAIL random%0d.err got=%0d want=%0d", p, n_err - b_err, ee); end
      n_tests++; if (n_supd - b_supd !== es) begin n_fail++; $display("FAIL random%0d.score_upd got=%0d want=%0d", p, n_supd - b_supd, es); end
      n_tests++; if (n_mupd - b_mupd !== em) begin n_fail++; $display("FAIL random%0d.map_upd got=%0d want=%0d", p, n_mupd - b_mupd, em); end
      n_tests++; if (o_score !== exp_score) begin n_fail++; $display("FAIL random%0d.score got=%h want=%h", p, o_score, exp_score); end
      n_tests++; if (o_map !== exp_map) begin n_fail++; $display("FAIL random%0d.map got=%h want=%h", p, o_map, exp_map); end
      n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL random%0d.busy got=%b want=0", p, o_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_connect();
    test_score_valid();
    test_score_bad();
    test_bad_cmd();
    test_timeout();
    test_reset_mid();
    test_clr_commit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_packet_ctrl.md
RX_PACKET_CTRL -- requirements
Module: rx_packet_ctrl

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, clock cycles per UART bit, passed to the receiver.
REQ-002 SHALL have parameter SCORE_BYTES, default 2, score payload length in bytes (1..8).
REQ-003 SHALL have parameter MAP_BYTES, default 16, map payload length in bytes (1..32).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 20*CLK_PER_BIT*10, the maximum idle cycles allowed between bytes within a packet.
REQ-005 Ports SHALL be: clk in 1, the single clock.
REQ-006 i_rst in 1, asynchronous active-high reset.
REQ-007 i_rx in 1, UART serial input, idle high.
REQ-008 i_clr in 1, synchronous clear of committed score/map.
REQ-009 o_ctrl_conn out 1, one-cycle pulse on connect command.
REQ-010 o_score_upd / o_map_upd out 1 each, one-cycle pulse on commit.
REQ-011 o_err out 1, one-cycle pulse on protocol error.
REQ-012 o_busy out 1, high while not in IDLE.
REQ-013 o_score out 8*SCORE_BYTES, committed score; o_map out 8*MAP_BYTES, committed map.

Function
REQ-014 Packet format: cmd byte, N payload bytes, 1 checksum byte = XOR of cmd and all payload bytes; cmd 0x00 connect (N=0, no checksum), 0x01 score (N=SCORE_BYTES), 0x02 map (N=MAP_BYTES).
REQ-015 States: IDLE, PAYLOAD, CHECK; a byte is the o_recv strobe of the internal receiver.
REQ-016 IDLE + byte 0x00: o_ctrl_conn SHALL pulse the next cycle, stay IDLE.
REQ-017 IDLE + byte 0x01/0x02: latch target, clear byte counter, init XOR to cmd, go PAYLOAD.
REQ-018 IDLE + any other byte: o_err SHALL pulse the next cycle, stay IDLE.
REQ-019 PAYLOAD: each byte SHALL go to the shadow buffer MSB-first (byte k at bits [8*(N-k)-1 -: 8]), XOR-accumulate, and increment the counter; after byte N-1, go CHECK.
REQ-020 CHECK + byte equal to accumulated XOR: copy shadow to the target output and pulse the matching _upd next cycle; otherwise pulse o_err with no output change; both cases return to IDLE.
REQ-021 Committed outputs SHALL change only on a valid commit, i_clr, or reset; partial packets SHALL never be visible.
REQ-022 Timeout: in PAYLOAD/CHECK, cycle counter reset on each byte; reaching TIMEOUT_CYC SHALL pulse o_err, discard the packet, and go IDLE.
REQ-023 i_clr SHALL zero o_score and o_map in any state without aborting reception; if a commit and i_clr occur in the same cycle, commit wins for its target.
REQ-024 Byte counter width SHALL be $clog2(max(SCORE_BYTES,MAP_BYTES)+1); no wrap is possible.
REQ-025 Bytes arriving in the same cycle as a timeout SHALL be ignored.

Reset
REQ-026 i_rst SHALL asynchronously force IDLE, zero counters, XOR, shadow, o_score and o_map, and deassert all pulses and o_busy; reset mid-packet discards it with no o_err.

Structure
REQ-027 Command codes, state encodings and the checksum width SHALL live in a shared constants include used by the transmitter side too.
REQ-028 SHALL instantiate exactly one sub-module, uart_rx (CLK_PER_BIT), outputs o_data[7:0] and o_recv strobe.

Verification
REQ-029 Send 0x00 -> exactly one o_ctrl_conn pulse, no other outputs change.
REQ-030 Send 01 12 34 27 -> o_score=0x1234, one o_score_upd pulse, o_err low.
REQ-031 Send 01 12 34 00 -> one o_err pulse, o_score unchanged, back to IDLE (o_busy low).
REQ-032 Send 02 plus 5 bytes, then silence > TIMEOUT_CYC -> one o_err pulse, o_map unchanged; a following valid map packet commits correctly.
REQ-033 Send 0x7F -> one o_err pulse; assert i_rst mid map packet -> all outputs zero, no o_err, next packet parsed normally.
REQ-034 Assert i_clr in the same cycle as a score commit -> o_score holds the new value and o_map reads 0.
